// File: rtl/mult_r4.sv
// mult_r4: unsigned multiply-add P = Q*D + R.
// Radix-4, MSB-first digit recurrence: one 2-bit digit of Q per cycle.
// After start is accepted the block takes WIDTH/2 CALC cycles, one ADD
// cycle and one DONE cycle, then returns to IDLE.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands latched on the accepting edge
// CALC  | acc <= 4*acc + digit*D, one digit of Q per edge
// ADD   | P <= acc + R
// DONE  | done pulse for one cycle, P valid

module mult_r4 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   Q,
  input  logic [WIDTH-1:0]   D,
  input  logic [WIDTH-1:0]   R,
  output logic [2*WIDTH-1:0] P,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(WIDTH / 2) + 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(WIDTH / 2 - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] ADD  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               busy_q, done_q;

  logic [1:0]         digit;
  logic [WIDTH+1:0]   d_ext;
  logic [WIDTH+1:0]   multiple;
  logic [2*WIDTH-1:0] acc_step;

  // Select the digit multiple of D; 3*D is built as (D<<1)+D so no multiplier is needed.
  always_comb begin
    digit    = q_q[WIDTH-1 -: 2];
    d_ext    = {2'b00, d_q};
    multiple = '0;
    case (digit)
      2'd0: multiple = '0;
      2'd1: multiple = d_ext;
      2'd2: multiple = d_ext << 1;
      2'd3: multiple = (d_ext << 1) + d_ext;
      default: multiple = '0;
    endcase
    // acc stays below Q*D <= (2^W-1)^2 at every step, so 2*WIDTH bits never overflow.
    acc_step = {acc_q[2*WIDTH-3:0], 2'b00} + {{(WIDTH-2){1'b0}}, multiple};
  end

  // Next-state and datapath update for each FSM state.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          q_d     = Q;
          d_d     = D;
          r_d     = R;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_step;
        q_d   = {q_q[WIDTH-3:0], 2'b00};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_DIGIT) begin
          state_d = ADD;
        end
      end
      ADD: begin
        p_d     = acc_q + {{WIDTH{1'b0}}, r_q};
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, operand and output registers; busy/done are derived from the next state so they are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign P    = p_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mult_r4.sv
// Testbench for mult_r4 (WIDTH=8): directed vectors feed a scoreboard queue,
// a monitor pops and compares P on every done pulse.

module tb_mult_r4;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   Q, D, R;
  logic [2*W-1:0] P;
  logic           busy, done;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int done_cnt  = 0;
  int cyc       = 0;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] mon_exp;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mult_r4 #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .Q    (Q),
    .D    (D),
    .R    (R),
    .P    (P),
    .busy (busy),
    .done (done)
  );

  task automatic check(input string name, input longint act, input longint expv);
    total_cnt++;
    if (act == expv) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        done_cnt++;
        check("sb_nonempty_on_done", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          mon_exp = exp_q.pop_front();
          check("P_result", P, mon_exp);
        end
      end
    end
  end

  // Wait (bounded) for the block to return to idle.
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_timeout"}, (n < 30) ? 1 : 0, 1);
  endtask

  task automatic issue(input logic [W-1:0] q, input logic [W-1:0] d,
                       input logic [W-1:0] r, input logic [2*W-1:0] expv);
    @(negedge clk);
    Q = q; D = d; R = r; start = 1'b1;
    exp_q.push_back(expv);
    @(negedge clk);
    start = 1'b0;
    wait_idle("issue");
  endtask

  typedef struct { int q; int d; int r; int p; } vec_t;
  vec_t vecs[5] = '{
    '{255, 255, 255, 65280},
    '{0,   200, 0,   0},
    '{1,   0,   255, 255},
    '{2,   3,   4,   10},
    '{170, 85,  3,   14453}
  };

  initial begin
    int busy_n, done_at, n0, k, n;
    int t[3];
    logic [W-1:0] rq, rd, rr;

    reset = 1'b1; start = 1'b0; Q = '0; D = '0; R = '0;
    repeat (2) @(negedge clk);
    check("reset_P", P, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    reset = 1'b0;

    // Latency and busy window: start at edge 0, done at edge 5, busy for 6 cycles.
    @(negedge clk);
    Q = 8'd13; D = 8'd10; R = 8'd7; start = 1'b1;
    exp_q.push_back(16'd137);
    @(negedge clk);
    start = 1'b0;
    busy_n = 0; done_at = -1;
    for (int i = 1; i <= 10; i++) begin
      if (busy) busy_n++;
      if (done) done_at = (done_at < 0) ? i : 99;
      @(negedge clk);
    end
    check("busy_cycles", busy_n, 6);
    check("done_position", done_at, 6);

    foreach (vecs[i])
      issue(vecs[i].q[W-1:0], vecs[i].d[W-1:0], vecs[i].r[W-1:0], vecs[i].p[2*W-1:0]);

    // Input changes and start pulses during CALC must not disturb the operation.
    @(negedge clk);
    Q = 8'd6; D = 8'd7; R = 8'd1; start = 1'b1;
    exp_q.push_back(16'd43);
    @(negedge clk);
    Q = 8'd200; D = 8'd200; R = 8'd200; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    n0 = done_cnt;
    wait_idle("ignore_start");
    repeat (10) @(negedge clk);
    check("single_op_during_calc", done_cnt - n0, 1);

    // Reset in the second CALC cycle clears outputs immediately.
    @(negedge clk);
    Q = 8'd13; D = 8'd10; R = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midop_reset_P", P, 0);
    check("midop_reset_busy", busy, 0);
    check("midop_reset_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    Q = 8'd9; D = 8'd11; R = 8'd5; start = 1'b1;
    exp_q.push_back(16'd104);
    @(negedge clk);
    start = 1'b0;
    check("accept_after_reset", busy, 1);
    wait_idle("after_reset");

    // start held high: back-to-back operations every 7 cycles.
    @(negedge clk);
    Q = 8'd3; D = 8'd3; R = 8'd0; start = 1'b1;
    repeat (3) exp_q.push_back(16'd9);
    k = 0; n = 0;
    while (k < 3 && n < 40) begin
      @(negedge clk);
      n++;
      if (done) begin
        t[k] = cyc;
        k++;
      end
    end
    start = 1'b0;
    check("b2b_done_count", k, 3);
    if (k == 3) begin
      check("b2b_interval_1", t[1] - t[0], 7);
      check("b2b_interval_2", t[2] - t[1], 7);
    end
    wait_idle("b2b");

    // Random operands against the arithmetic reference.
    for (int i = 0; i < 300; i++) begin
      rq = W'($urandom_range(0, 255));
      rd = W'($urandom_range(0, 255));
      rr = W'($urandom_range(0, 255));
      issue(rq, rd, rr, ({8'd0, rq} * {8'd0, rd}) + {8'd0, rr});
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
    $fatal(1, "watchdog");
  end

endmodule
